// File: rtl/adder_multicycle.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands summed CHUNK bits per clock, LSB chunk first.
// Define ADDER_FLAGS_EN to add registered ovf/zero/neg outputs.

module adder_multicycle_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] s_o,
  output logic             c_o
);
  assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, c_i};
endmodule

module adder_multicycle #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             carry
`ifdef ADDER_FLAGS_EN
  ,
  output logic             ovf,
  output logic             zero,
  output logic             neg
`endif
);
  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH % CHUNK) != 0 || CHUNK < 1) begin : g_bad_cfg
    $error("adder_multicycle: WIDTH must be a nonzero multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                     state_q, state_d;
  logic [N-1:0][CHUNK-1:0]    a_q, a_d, b_q, b_d, w_q, w_d;
  logic                       c_q, c_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [WIDTH-1:0]           res_q, res_d;
  logic                       carry_q, carry_d;
  logic [CHUNK-1:0]           sum;
  logic                       cout;
  logic                       last;

  adder_multicycle_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_i (a_q[idx_q]),
    .b_i (b_q[idx_q]),
    .c_i (c_q),
    .s_o (sum),
    .c_o (cout)
  );

  assign last = (idx_q == IW'(N - 1));

`ifdef ADDER_FLAGS_EN
  logic ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    w_d     = w_q;
    c_d     = c_q;
    idx_d   = idx_q;
    res_d   = res_q;
    carry_d = carry_q;
`ifdef ADDER_FLAGS_EN
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
`endif
    unique case (state_q)
      IDLE: if (start) begin
        a_d     = op1;
        b_d     = sub ? ~op2 : op2;
        c_d     = sub;
        idx_d   = '0;
        w_d     = '0;
        state_d = RUN;
      end
      RUN: begin
        w_d[idx_q] = sum;
        c_d        = cout;
        idx_d      = idx_q + 1'b1;
        // Result registers are only touched on the final chunk so partial sums never leak out.
        if (last) begin
          res_d   = w_d;
          carry_d = cout;
          idx_d   = '0;
          state_d = DONE;
`ifdef ADDER_FLAGS_EN
          ovf_d   = (a_q[N-1][CHUNK-1] == b_q[N-1][CHUNK-1]) &&
                    (w_d[N-1][CHUNK-1] != a_q[N-1][CHUNK-1]);
          zero_d  = (w_d == '0);
          neg_d   = w_d[N-1][CHUNK-1];
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      w_q     <= '0;
      c_q     <= 1'b0;
      idx_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      w_q     <= w_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      carry_q <= carry_d;
    end
  end

`ifdef ADDER_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      neg_q  <= neg_d;
    end
  end

  assign ovf  = ovf_q;
  assign zero = zero_q;
  assign neg  = neg_q;
`endif

  assign ready = (state_q == IDLE);
  assign done  = (state_q == DONE);
  assign res   = res_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_adder_multicycle.sv
// Self-checking bench for adder_multicycle (WIDTH=32, CHUNK=8): directed vectors plus random ops vs. arithmetic model.

module tb_adder_multicycle;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst, start, sub;
  logic [31:0] op1, op2;
  logic        ready, done, carry;
  logic [31:0] res;
`ifdef ADDER_FLAGS_EN
  logic        ovf, zero, neg;
`endif

  int errors = 0;
  int checks = 0;

  adder_multicycle #(.WIDTH(32), .CHUNK(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .op1   (op1),
    .op2   (op2),
    .ready (ready),
    .done  (done),
    .res   (res),
    .carry (carry)
`ifdef ADDER_FLAGS_EN
    ,
    .ovf   (ovf),
    .zero  (zero),
    .neg   (neg)
`endif
  );

  always #5 clk = ~clk;

  // Reference: plain modular arithmetic; carry means unsigned overflow (add) or no borrow (sub).
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] r, output logic c, output logic v);
    if (s) begin
      r = a - b;
      c = (a >= b);
      v = (a[31] != b[31]) && (r[31] != a[31]);
    end else begin
      r = a + b;
      c = ({1'b0, a} + {1'b0, b}) > 33'h0FFFFFFFF;
      v = (a[31] == b[31]) && (r[31] != a[31]);
    end
  endfunction

  // Issues one op when ready, scrambles inputs after accept, waits for done (bounded).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [31:0] r, output logic c, output int lat, output bit ok,
                        output logic fv, output logic fz, output logic fn);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    op1 = a; op2 = b; sub = s; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; op1 = $urandom; op2 = $urandom; sub = 1'($urandom);
    lat = 0; ok = 1'b0;
    repeat (20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    r = res; c = carry;
`ifdef ADDER_FLAGS_EN
    fv = ovf; fz = zero; fn = neg;
`else
    fv = 1'b0; fz = 1'b0; fn = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sub = 1'b0; op1 = '0; op2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ready, done, carry, res} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL reset_state got ready=%b done=%b carry=%b res=%0h exp 1 0 0 0", ready, done, carry, res);
    end
    rst = 1'b0;
  endtask

  logic [31:0] ta [8] = '{32'd15, 32'd20, 32'd20, 32'd5, 32'd25, 32'h000000FF, 32'hFFFFFFFF, 32'h7FFFFFFF};
  logic [31:0] tb [8] = '{32'd10, 32'd5, 32'hFFFFFFFB, 32'd20, 32'd999, 32'd1, 32'd1, 32'd1};
  logic        ts [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [31:0] te [8] = '{32'd25, 32'd15, 32'd15, 32'hFFFFFFF1, 32'd1024, 32'h100, 32'd0, 32'h80000000};
  logic        tc [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic        tv [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  task automatic test_directed();
    logic [31:0] r;
    logic c, fv, fz, fn;
    int lat;
    bit ok;
    for (int i = 0; i < 8; i++) begin
      run_op(ta[i], tb[i], ts[i], r, c, lat, ok, fv, fz, fn);
      checks++;
      if (!ok || lat != N) begin
        errors++;
        $display("FAIL directed%0d_latency got=%0d done_seen=%0b exp=%0d", i, lat, ok, N);
      end
      checks++;
      if ({c, r} !== {tc[i], te[i]}) begin
        errors++;
        $display("FAIL directed%0d_result got=%0h carry=%b exp=%0h carry=%b", i, r, c, te[i], tc[i]);
      end
`ifdef ADDER_FLAGS_EN
      checks++;
      if ({fv, fz, fn} !== {tv[i], te[i] == 32'd0, te[i][31]}) begin
        errors++;
        $display("FAIL directed%0d_flags got ovf/zero/neg=%b%b%b exp=%b%b%b", i, fv, fz, fn,
                 tv[i], te[i] == 32'd0, te[i][31]);
      end
`endif
      @(negedge clk);
      checks++;
      if ({ready, done} !== 2'b10) begin
        errors++;
        $display("FAIL directed%0d_ready_after got ready=%b done=%b exp 1 0", i, ready, done);
      end
    end
  endtask

  task automatic test_start_ignored();
    int lat, extra;
    bit seen;
    @(negedge clk);
    op1 = 32'd100; op2 = 32'd23; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op1 = 32'd7; op2 = 32'd7; sub = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 2; seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
      @(posedge clk);
      lat++;
    end
    checks++;
    if (!seen || lat != N || res !== 32'd123 || carry !== 1'b0) begin
      errors++;
      $display("FAIL start_in_run got lat=%0d seen=%0b res=%0h carry=%b exp lat=%0d res=7b carry=0",
               lat, seen, res, carry, N);
    end
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL start_in_run_queued got extra_done=%0d exp=0", extra);
    end
  endtask

  task automatic test_hold_start();
    int ndone;
    @(negedge clk);
    op1 = 32'd1000; op2 = 32'd1; sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    op1 = 32'd40; op2 = 32'd2; sub = 1'b0;
    ndone = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      if (i == 6) begin #1 start = 1'b0; end
      @(negedge clk);
      if (done) begin
        ndone++;
        if (i == 4) begin
          checks++;
          if ({carry, res} !== {1'b1, 32'd999}) begin
            errors++;
            $display("FAIL hold_start_first got res=%0d carry=%b exp 999 1", res, carry);
          end
        end else if (i == 10) begin
          checks++;
          if ({carry, res} !== {1'b0, 32'd42}) begin
            errors++;
            $display("FAIL hold_start_second got res=%0d carry=%b exp 42 0", res, carry);
          end
        end else begin
          checks++; errors++;
          $display("FAIL hold_start_timing got done at cycle %0d exp cycles 4 and 10", i);
        end
      end
    end
    checks++;
    if (ndone != 2) begin
      errors++;
      $display("FAIL hold_start_count got=%0d exp=2", ndone);
    end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] r, er;
    logic c, ec, ev, fv, fz, fn;
    int lat, seen;
    bit ok;
    @(negedge clk);
    op1 = 32'h12345678; op2 = 32'h11111111; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ready, done, carry, res} !== {1'b1, 1'b0, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL reset_midrun got ready=%b done=%b carry=%b res=%0h exp 1 0 0 0", ready, done, carry, res);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_midrun_done got=%0d pulses exp=0", seen);
    end
    run_op(32'hDEADBEEF, 32'h0BADF00D, 1'b1, r, c, lat, ok, fv, fz, fn);
    model(32'hDEADBEEF, 32'h0BADF00D, 1'b1, er, ec, ev);
    checks++;
    if (!ok || {c, r} !== {ec, er}) begin
      errors++;
      $display("FAIL reset_midrun_after got res=%0h carry=%b done=%0b exp res=%0h carry=%b", r, c, ok, er, ec);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r, er;
    logic s, c, ec, ev, fv, fz, fn;
    int lat;
    bit ok;
    for (int i = 0; i < 40; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom);
      if (i % 8 == 0) b = a;
      if (i % 8 == 1) a = 32'hFFFFFFFF;
      run_op(a, b, s, r, c, lat, ok, fv, fz, fn);
      model(a, b, s, er, ec, ev);
      checks++;
      if (!ok || lat != N || {c, r} !== {ec, er}) begin
        errors++;
        $display("FAIL random%0d a=%0h b=%0h sub=%b got res=%0h carry=%b lat=%0d exp res=%0h carry=%b lat=%0d",
                 i, a, b, s, r, c, lat, er, ec, N);
      end
`ifdef ADDER_FLAGS_EN
      checks++;
      if ({fv, fz, fn} !== {ev, er == 32'd0, er[31]}) begin
        errors++;
        $display("FAIL random%0d_flags got=%b%b%b exp=%b%b%b", i, fv, fz, fn, ev, er == 32'd0, er[31]);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_hold_start();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
